operand_collector: RTL and testbench
====================================

// Module: operand_collector
// PURPOSE
//  Requester side of the register file bank read interface. Accepts one decoded instruction
//  with up to NumOperands source register addresses, then issues tagged read requests to the
//  bank. Collects the tagged read responses and presents the instruction plus all operand data
//  to the execution stage over a valid/ready handshake. Sits between dispatcher and execute.
// PARAMETERS
//  NumOperands   3     source operands per instruction (>= 1)
//  NumRegisters  256   registers in the bank; AddrWidth = $clog2(NumRegisters)
//  DataWidth     32    bits per register
//  TagWidth      8     read tag width; must be >= $clog2(NumOperands), elaboration error if not
//  InstWidth     32    opaque instruction payload width
// PORTS
//  clk_i             in   1                      clock
//  rst_i             in   1                      reset, synchronous, active-high
//  inst_valid_i      in   1                      instruction valid
//  inst_ready_o      out  1                      instruction ready
//  inst_i            in   InstWidth              instruction payload
//  inst_op_used_i    in   NumOperands            bit k set: operand k must be read
//  inst_op_addr_i    in   NumOperands*AddrWidth  register address of operand k (slice k)
//  read_valid_o      out  1                      read request valid to bank
//  read_ready_i      in   1                      bank accepts request
//  read_addr_o       out  AddrWidth              requested register
//  read_tag_o        out  TagWidth               tag = operand index k, upper bits zero
//  read_valid_i      in   1                      bank response valid (no backpressure)
//  read_tag_i        in   TagWidth               response tag
//  read_data_i       in   DataWidth              response data
//  disp_valid_o      out  1                      instruction + operands valid
//  disp_ready_i      in   1                      execute stage accepts
//  disp_inst_o       out  InstWidth              latched instruction
//  disp_operands_o   out  NumOperands*DataWidth  operand k data (slice k)
// BEHAVIOUR
//  - One clock, one reset. While rst_i=1 and on the first cycle after: state IDLE,
//    all valid/ready outputs 0 during reset, masks cleared, operand regs 0.
//  - FSM: IDLE -> ISSUE -> WAIT -> DISPATCH -> IDLE.
//  - IDLE: inst_ready_o=1. On handshake, latch inst_i, inst_op_addr_i, used mask; clear
//    issued/received masks and operand regs. Next state ISSUE, or DISPATCH if mask==0.
//  - ISSUE: read_valid_o=1 for lowest-index used operand not yet issued; addr/tag held
//    stable until read_ready_i. On handshake mark issued; when last one issued -> WAIT.
//  - Responses accepted in every non-IDLE state, including the ISSUE cycle they arrive in.
//    Response with tag that is not issued-and-not-received (or >= NumOperands) is dropped.
//    Valid response writes read_data_i into operand slot tag, sets received bit.
//  - WAIT (and ISSUE): when received mask == used mask, the capturing edge moves to DISPATCH.
//  - DISPATCH: disp_valid_o=1, disp_inst_o/disp_operands_o stable; unused slots read 0.
//    On disp_ready_i handshake -> IDLE. No inst_i -> disp_* combinational path.
//  - Latency (bank 1-cycle, read_ready_i=1, disp_ready_i=1): accept at cycle 0, requests
//    cycles 1..N, disp_valid_o first high at cycle N+2 for N used operands; 1 for N=0.
//  - Same register in two slots: two separate requests, both slots filled.
//  - Reset mid-operation: transaction discarded; responses after reset are dropped (no
//    issued bits), no dispatch emitted.
//  - Throughput: one instruction in flight; inst_ready_o=0 outside IDLE.
// TESTING
//  - 3 ops addr 5,9,200, bank regs=k*3, ready=1 -> reads tag 0,1,2 in cycles 1-3;
//    disp_valid at cycle 5 with operands 15,27,600.
//  - used=3'b010 addr 7 -> one request tag 1; disp slot1=reg7 data, slots 0,2 = 0.
//  - used=0 -> no read_valid_o; disp_valid_o at cycle 1 with inst_i echoed.
//  - read_ready_i low 4 cycles on op0 -> read_valid_o, addr, tag stable all 4 cycles.
//  - Responses out of order (tag 2,0,1) plus stray tag 5 -> correct slots, stray ignored.
//  - disp_ready_i low 10 cycles -> disp outputs stable, inst_ready_o=0; rst_i mid-WAIT ->
//    IDLE next cycle, no disp_valid_o.

Source files
------------

// File: rtl/operand_collector.sv
// Operand collector: latches one decoded instruction, issues tagged register-bank reads,
// gathers the responses in any order, then hands instruction plus operands to execute.
module operand_collector #(
    parameter int  NumOperands  = 3,
    parameter int  NumRegisters = 256,
    parameter int  DataWidth    = 32,
    parameter int  TagWidth     = 8,
    parameter int  InstWidth    = 32,
    localparam int AddrWidth    = $clog2(NumRegisters)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             inst_valid_i,
    output logic                             inst_ready_o,
    input  logic [InstWidth-1:0]             inst_i,
    input  logic [NumOperands-1:0]           inst_op_used_i,
    input  logic [NumOperands*AddrWidth-1:0] inst_op_addr_i,
    output logic                             read_valid_o,
    input  logic                             read_ready_i,
    output logic [AddrWidth-1:0]             read_addr_o,
    output logic [TagWidth-1:0]              read_tag_o,
    input  logic                             read_valid_i,
    input  logic [TagWidth-1:0]              read_tag_i,
    input  logic [DataWidth-1:0]             read_data_i,
    output logic                             disp_valid_o,
    input  logic                             disp_ready_i,
    output logic [InstWidth-1:0]             disp_inst_o,
    output logic [NumOperands*DataWidth-1:0] disp_operands_o,
    output logic [1:0]                       dbg_state_o
);

    localparam int IdxW = (NumOperands > 1) ? $clog2(NumOperands) : 1;

    if (TagWidth < $clog2(NumOperands)) begin : g_tag_width_check
        $error("operand_collector: TagWidth too narrow to encode every operand index");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT     = 2'd2,
        S_DISPATCH = 2'd3
    } state_t;

    state_t                           r_state;
    logic [InstWidth-1:0]             r_inst;
    logic [NumOperands*AddrWidth-1:0] r_addr;
    logic [NumOperands-1:0]           r_used;
    logic [NumOperands-1:0]           r_issued;
    logic [NumOperands-1:0]           r_recv;
    logic [NumOperands*DataWidth-1:0] r_operands;

    logic [NumOperands-1:0] w_pending;
    logic [NumOperands-1:0] w_issue_oh;
    logic [IdxW-1:0]        w_issue_idx;
    logic [NumOperands-1:0] w_resp_hit;
    logic [NumOperands-1:0] w_recv_next;
    logic [NumOperands-1:0] w_issued_next;

    assign w_pending = r_used & ~r_issued;

    // Lowest-index pending operand wins; it cannot change until its request is accepted.
    always_comb begin
        w_issue_idx = '0;
        w_issue_oh  = '0;
        for (int k = NumOperands - 1; k >= 0; k--) begin
            if (w_pending[k]) begin
                w_issue_idx   = IdxW'(k);
                w_issue_oh    = '0;
                w_issue_oh[k] = 1'b1;
            end
        end
    end

    // A response counts only for an operand that was issued and has not yet returned.
    always_comb begin
        w_resp_hit = '0;
        for (int k = 0; k < NumOperands; k++) begin
            w_resp_hit[k] = read_valid_i && (r_state != S_IDLE) &&
                            (read_tag_i == TagWidth'(k)) && r_issued[k] && !r_recv[k];
        end
    end

    assign w_recv_next   = r_recv | w_resp_hit;
    assign w_issued_next = r_issued | (read_ready_i ? w_issue_oh : '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_inst     <= '0;
            r_addr     <= '0;
            r_used     <= '0;
            r_issued   <= '0;
            r_recv     <= '0;
            r_operands <= '0;
        end else begin
            r_recv <= w_recv_next;
            for (int k = 0; k < NumOperands; k++) begin
                if (w_resp_hit[k]) begin
                    r_operands[k*DataWidth +: DataWidth] <= read_data_i;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (inst_valid_i) begin
                        r_inst     <= inst_i;
                        r_addr     <= inst_op_addr_i;
                        r_used     <= inst_op_used_i;
                        r_issued   <= '0;
                        r_recv     <= '0;
                        r_operands <= '0;
                        r_state    <= (inst_op_used_i == '0) ? S_DISPATCH : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_issued <= w_issued_next;
                    if (w_recv_next == r_used) begin
                        r_state <= S_DISPATCH;
                    end else if (w_issued_next == r_used) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_recv_next == r_used) begin
                        r_state <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (disp_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and payload stays stable while valid is high and ready low.
    assign inst_ready_o    = !rst_i && (r_state == S_IDLE);
    assign read_valid_o    = !rst_i && (r_state == S_ISSUE) && (w_pending != '0);
    assign read_addr_o     = r_addr[int'(w_issue_idx)*AddrWidth +: AddrWidth];
    assign read_tag_o      = TagWidth'(w_issue_idx);
    assign disp_valid_o    = !rst_i && (r_state == S_DISPATCH);
    assign disp_inst_o     = r_inst;
    assign disp_operands_o = r_operands;
    assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector: bank model with 1-cycle latency, request scoreboard,
// hand-computed operand values and dispatch latencies.
module tb_operand_collector;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        inst_valid_i;
    logic        inst_ready_o;
    logic [31:0] inst_i;
    logic [2:0]  inst_op_used_i;
    logic [23:0] inst_op_addr_i;
    logic        read_valid_o;
    logic        read_ready_i;
    logic [7:0]  read_addr_o;
    logic [7:0]  read_tag_o;
    logic        read_valid_i;
    logic [7:0]  read_tag_i;
    logic [31:0] read_data_i;
    logic        disp_valid_o;
    logic        disp_ready_i;
    logic [31:0] disp_inst_o;
    logic [95:0] disp_operands_o;
    logic [1:0]  dbg_state_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          bank_auto = 1'b1;
    logic [15:0] exp_q[$];
    int          req_cyc_q[$];

    operand_collector dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .inst_valid_i    (inst_valid_i),
        .inst_ready_o    (inst_ready_o),
        .inst_i          (inst_i),
        .inst_op_used_i  (inst_op_used_i),
        .inst_op_addr_i  (inst_op_addr_i),
        .read_valid_o    (read_valid_o),
        .read_ready_i    (read_ready_i),
        .read_addr_o     (read_addr_o),
        .read_tag_o      (read_tag_o),
        .read_valid_i    (read_valid_i),
        .read_tag_i      (read_tag_i),
        .read_data_i     (read_data_i),
        .disp_valid_o    (disp_valid_o),
        .disp_ready_i    (disp_ready_i),
        .disp_inst_o     (disp_inst_o),
        .disp_operands_o (disp_operands_o),
        .dbg_state_o     (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: score the request of the current cycle, cross the edge, then let the bank
    // answer an accepted request one cycle later.
    task automatic step();
        logic       rv;
        logic [7:0] rt;
        logic [7:0] ra;
        rv = read_valid_o && read_ready_i;
        rt = read_tag_o;
        ra = read_addr_o;
        if (rv) begin
            req_cyc_q.push_back(cyc);
            check("req_expected", 128'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("req_tag_addr", {rt, ra}, exp_q.pop_front());
        end
        @(posedge clk_i);
        #1;
        cyc++;
        if (bank_auto) begin
            read_valid_i = rv;
            read_tag_i   = rt;
            read_data_i  = 32'(32'(ra) * 3);
        end
    endtask

    task automatic start_inst(input string name, input logic [31:0] inst,
                              input logic [2:0] used, input logic [23:0] addrs);
        check({name, "_inst_ready"}, inst_ready_o, 1);
        for (int k = 0; k < 3; k++) begin
            if (used[k]) exp_q.push_back({8'(k), addrs[k*8 +: 8]});
        end
        req_cyc_q.delete();
        inst_valid_i   = 1'b1;
        inst_i         = inst;
        inst_op_used_i = used;
        inst_op_addr_i = addrs;
        cyc            = 0;
        step();
        inst_valid_i   = 1'b0;
        inst_i         = 32'hDEAD_BEEF;
        inst_op_used_i = 3'b111;
        inst_op_addr_i = 24'hFFFFFF;
    endtask

    task automatic finish_inst(input string name, input logic [31:0] inst,
                               input int exp_cyc, input logic [95:0] exp_ops);
        while (!disp_valid_o && cyc < 60) step();
        check({name, "_disp_cycle"}, cyc, exp_cyc);
        check({name, "_disp_inst"}, disp_inst_o, inst);
        check({name, "_disp_ops"}, disp_operands_o, exp_ops);
        check({name, "_reqs_left"}, exp_q.size(), 0);
        if (disp_ready_i) begin
            step();
            check({name, "_back_idle"}, {disp_valid_o, inst_ready_o}, 2'b01);
        end
    endtask

    initial begin
        rst_i          = 1'b1;
        inst_valid_i   = 1'b0;
        inst_i         = '0;
        inst_op_used_i = '0;
        inst_op_addr_i = '0;
        read_ready_i   = 1'b1;
        read_valid_i   = 1'b0;
        read_tag_i     = '0;
        read_data_i    = '0;
        disp_ready_i   = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_outputs", {inst_ready_o, read_valid_o, disp_valid_o}, 3'b000);
        check("rst_state", dbg_state_o, 0);
        rst_i = 1'b0;
        step();
        check("post_rst_ready", inst_ready_o, 1);
        check("post_rst_ops", disp_operands_o, 0);

        // Three operands, bank data = addr*3, everything ready.
        start_inst("three", 32'h1111_0003, 3'b111, {8'd200, 8'd9, 8'd5});
        finish_inst("three", 32'h1111_0003, 5, {32'd600, 32'd27, 32'd15});
        check("three_req_count", req_cyc_q.size(), 3);
        if (req_cyc_q.size() == 3) begin
            check("three_req_cyc0", req_cyc_q[0], 1);
            check("three_req_cyc1", req_cyc_q[1], 2);
            check("three_req_cyc2", req_cyc_q[2], 3);
        end

        start_inst("single", 32'h2222_0001, 3'b010, {8'd0, 8'd7, 8'd0});
        finish_inst("single", 32'h2222_0001, 3, {32'd0, 32'd21, 32'd0});

        start_inst("none", 32'hCAFE_0001, 3'b000, {8'd1, 8'd2, 8'd3});
        finish_inst("none", 32'hCAFE_0001, 1, 96'd0);

        start_inst("samereg", 32'h3333_0005, 3'b101, {8'd8, 8'd99, 8'd8});
        finish_inst("samereg", 32'h3333_0005, 4, {32'd24, 32'd0, 32'd24});

        // Bank stalls the first request for four cycles.
        start_inst("stall", 32'h4444_0003, 3'b011, {8'd0, 8'd11, 8'd10});
        read_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stall_hold", {read_valid_o, read_tag_o, read_addr_o}, {1'b1, 8'd0, 8'd10});
            step();
        end
        read_ready_i = 1'b1;
        finish_inst("stall", 32'h4444_0003, 8, {32'd0, 32'd33, 32'd30});

        // Manual bank: out-of-order responses plus a stray tag and a duplicate.
        bank_auto = 1'b0;
        start_inst("ooo", 32'h5555_0007, 3'b111, {8'd3, 8'd2, 8'd1});
        step();
        step();
        step();
        read_valid_i = 1'b1; read_tag_i = 8'd2; read_data_i = 32'hA2; step();
        read_tag_i = 8'd5; read_data_i = 32'hFF; step();
        read_tag_i = 8'd2; read_data_i = 32'hEE; step();
        read_tag_i = 8'd0; read_data_i = 32'hA0; step();
        read_tag_i = 8'd1; read_data_i = 32'hA1; step();
        read_valid_i = 1'b0;
        finish_inst("ooo", 32'h5555_0007, 9, {32'hA2, 32'hA1, 32'hA0});
        bank_auto = 1'b1;

        // Execute stage holds off for ten cycles.
        disp_ready_i = 1'b0;
        start_inst("dstall", 32'h6666_0001, 3'b001, {8'd0, 8'd0, 8'd4});
        finish_inst("dstall", 32'h6666_0001, 3, {32'd0, 32'd0, 32'd12});
        for (int i = 0; i < 10; i++) begin
            check("dstall_hold", {disp_valid_o, inst_ready_o, disp_inst_o, disp_operands_o},
                  {1'b1, 1'b0, 32'h6666_0001, 32'd0, 32'd0, 32'd12});
            step();
        end
        disp_ready_i = 1'b1;
        step();
        check("dstall_release", {disp_valid_o, inst_ready_o}, 2'b01);

        // Reset while waiting for a response; the late response must be dropped.
        bank_auto = 1'b0;
        start_inst("rstwait", 32'h7777_0001, 3'b001, {8'd0, 8'd0, 8'd6});
        step();
        check("rstwait_state", dbg_state_o, 2);
        rst_i = 1'b1;
        step();
        check("rstwait_in_rst", {inst_ready_o, read_valid_o, disp_valid_o}, 3'b000);
        rst_i        = 1'b0;
        read_valid_i = 1'b1;
        read_tag_i   = 8'd0;
        read_data_i  = 32'h66;
        step();
        check("rstwait_idle", {inst_ready_o, dbg_state_o}, {1'b1, 2'd0});
        read_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rstwait_no_disp", {disp_valid_o, inst_ready_o}, 2'b01);
            step();
        end
        check("rstwait_ops_clear", disp_operands_o, 0);
        bank_auto = 1'b1;

        start_inst("recover", 32'h8888_0002, 3'b110, {8'd50, 8'd40, 8'd0});
        finish_inst("recover", 32'h8888_0002, 4, {32'd150, 32'd120, 32'd0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
